// File: rtl/ivector_pkg.sv
// ivector_pkg: shared word layout, default field widths and round-robin helper
package ivector_pkg;
  localparam int IVECTOR_METH_W = 6;
  localparam int IVECTOR_V_W = 4;
  typedef struct packed {
    logic [IVECTOR_V_W-1:0] v;
    logic [IVECTOR_METH_W-1:0] meth;
  } ivector_word_t;
  function automatic int rr_next(input int ptr, input int nchan);
    return (ptr + 1) % nchan;
  endfunction
endpackage

// File: rtl/ivector_fifo.sv
// ivector_fifo: DEPTH-entry per-channel FIFO, async active-low reset
// Ports: CLK, nRST; enq_ena/enq_data/enq_rdy (not full); deq_ena/deq_rdy (not empty); first (head word); count (occupancy)
module ivector_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic enq_ena,
  input  logic [WIDTH-1:0] enq_data,
  output logic enq_rdy,
  input  logic deq_ena,
  output logic deq_rdy,
  output logic [WIDTH-1:0] first,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign enq_rdy = count != (AW+1)'(DEPTH);
  assign deq_rdy = count != '0;
  // Writes while full are protocol errors and are dropped here.
  assign wr = enq_ena & enq_rdy;
  assign rd = deq_ena & deq_rdy;
  assign first = mem[rp];
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge CLK)
    if (wr) mem[wp] <= enq_data;
endmodule

// File: rtl/ivector_arb.sv
// ivector_arb: NCHAN request FIFOs drained round-robin onto one tagged indication port
module ivector_arb
  import ivector_pkg::*;
#(
  parameter int NCHAN = 4,
  parameter int METH_W = IVECTOR_METH_W,
  parameter int V_W = IVECTOR_V_W,
  parameter int DEPTH = 4,
  localparam int CHAN_W = $clog2(NCHAN)
) (
  input  logic CLK,
  input  logic nRST,
  input  logic [NCHAN-1:0] request_say__ENA,
  input  logic [NCHAN*METH_W-1:0] request_say_meth,
  input  logic [NCHAN*V_W-1:0] request_say_v,
  output logic [NCHAN-1:0] request_say__RDY,
  output logic ind_heard__ENA,
  output logic [METH_W-1:0] ind_heard_meth,
  output logic [V_W-1:0] ind_heard_v,
  output logic [CHAN_W-1:0] ind_heard_chan,
  input  logic ind_heard__RDY
`ifdef IVECTOR_ARB_STATS_EN
  ,
  output logic [31:0] stat_heard_count,
  output logic [NCHAN-1:0] stat_full
`endif
);
  localparam int W = V_W + METH_W;
  logic [W-1:0] head [NCHAN];
  logic [$clog2(DEPTH):0] cnt [NCHAN];
  logic [NCHAN-1:0] has, nempty, deq;
  logic [CHAN_W-1:0] rr_ptr, grant;
  logic any;
  logic [W-1:0] sel;
  for (genvar i = 0; i < NCHAN; i++) begin : g_ch
    ivector_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
      .CLK(CLK),
      .nRST(nRST),
      .enq_ena(request_say__ENA[i]),
      .enq_data({request_say_v[i*V_W +: V_W], request_say_meth[i*METH_W +: METH_W]}),
      .enq_rdy(request_say__RDY[i]),
      .deq_ena(deq[i]),
      .deq_rdy(nempty[i]),
      .first(head[i]),
      .count(cnt[i])
    );
    assign has[i] = cnt[i] != '0;
    assign deq[i] = ind_heard__ENA & (grant == CHAN_W'(i)) & nempty[i];
  end
  always_comb begin
    grant = '0;
    any = 1'b0;
    for (int k = NCHAN - 1; k >= 0; k--)
      if (has[CHAN_W'((int'(rr_ptr) + k) % NCHAN)]) begin
        grant = CHAN_W'((int'(rr_ptr) + k) % NCHAN);
        any = 1'b1;
      end
  end
  assign sel = head[grant];
  assign ind_heard__ENA = any & ind_heard__RDY;
  assign ind_heard_meth = any ? sel[METH_W-1:0] : '0;
  assign ind_heard_v = any ? sel[W-1:METH_W] : '0;
  assign ind_heard_chan = any ? grant : '0;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) rr_ptr <= '0;
    else if (ind_heard__ENA) rr_ptr <= CHAN_W'(rr_next(int'(grant), NCHAN));
`ifdef IVECTOR_ARB_STATS_EN
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      stat_heard_count <= '0;
      stat_full <= '0;
    end else begin
      stat_heard_count <= stat_heard_count + 32'(ind_heard__ENA);
      stat_full <= stat_full | ~request_say__RDY;
    end
`endif
endmodule

// File: tb/tb_ivector_arb.sv
// tb_ivector_arb: table-driven and directed checks for ivector_arb (NCHAN=4, DEPTH=4)
module tb_ivector_arb;
  import ivector_pkg::*;
  logic CLK = 0;
  logic nRST = 0;
  always #5 CLK = ~CLK;
  logic [3:0] say_ena = '0;
  logic [23:0] say_meth = '0;
  logic [15:0] say_v = '0;
  logic [3:0] say_rdy;
  logic h_ena;
  logic [5:0] h_meth;
  logic [3:0] h_v;
  logic [1:0] h_chan;
  logic h_rdy = 0;
`ifdef IVECTOR_ARB_STATS_EN
  logic [31:0] st_cnt;
  logic [3:0] st_full;
`endif
  int n_cmp = 0;
  int n_fail = 0;

  ivector_arb #(.NCHAN(4), .METH_W(6), .V_W(4), .DEPTH(4)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .request_say__ENA(say_ena),
    .request_say_meth(say_meth),
    .request_say_v(say_v),
    .request_say__RDY(say_rdy),
    .ind_heard__ENA(h_ena),
    .ind_heard_meth(h_meth),
    .ind_heard_v(h_v),
    .ind_heard_chan(h_chan),
    .ind_heard__RDY(h_rdy)
`ifdef IVECTOR_ARB_STATS_EN
    ,
    .stat_heard_count(st_cnt),
    .stat_full(st_full)
`endif
  );

  typedef struct {
    logic [3:0] ena;
    logic [23:0] meth;
    logic [15:0] v;
    logic hrdy;
    logic [3:0] e_rdy;
    logic e_ena;
    logic [5:0] e_meth;
    logic [3:0] e_v;
    logic [1:0] e_chan;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] ena, input logic [23:0] meth, input logic [15:0] v,
                              input logic hrdy, input logic [3:0] e_rdy, input logic e_ena,
                              input logic [5:0] e_meth, input logic [3:0] e_v, input logic [1:0] e_chan);
    vec_t r;
    r.ena = ena; r.meth = meth; r.v = v; r.hrdy = hrdy; r.e_rdy = e_rdy;
    r.e_ena = e_ena; r.e_meth = e_meth; r.e_v = e_v; r.e_chan = e_chan;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int mcnt;
    logic [9:0] q[$];
    logic [9:0] w;
    // reset then idle
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("inrst_rdy", say_rdy, 4'hF);
    chk("inrst_ena", h_ena, 0);
    nRST = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      @(negedge CLK);
      chk("idle_rdy", say_rdy, 4'hF);
      chk("idle_ena", h_ena, 0);
    end
    // round-robin: ch0, ch1, ch3 two words each
    tbl.push_back(mk(4'b1011, {6'h13, 6'h00, 6'h11, 6'h10}, {4'h3, 4'h0, 4'h1, 4'h0}, 0, 4'hF, 0, 6'h00, 4'h0, 2'd0));
    tbl.push_back(mk(4'b1011, {6'h23, 6'h00, 6'h21, 6'h20}, {4'h7, 4'h0, 4'h5, 4'h4}, 0, 4'hF, 0, 6'h10, 4'h0, 2'd0));
    tbl.push_back(mk(4'b0000, '0, '0, 1, 4'hF, 1, 6'h10, 4'h0, 2'd0));
    tbl.push_back(mk(4'b0000, '0, '0, 1, 4'hF, 1, 6'h11, 4'h1, 2'd1));
    tbl.push_back(mk(4'b0000, '0, '0, 1, 4'hF, 1, 6'h13, 4'h3, 2'd3));
    tbl.push_back(mk(4'b0000, '0, '0, 1, 4'hF, 1, 6'h20, 4'h4, 2'd0));
    tbl.push_back(mk(4'b0000, '0, '0, 1, 4'hF, 1, 6'h21, 4'h5, 2'd1));
    tbl.push_back(mk(4'b0000, '0, '0, 1, 4'hF, 1, 6'h23, 4'h7, 2'd3));
    tbl.push_back(mk(4'b0000, '0, '0, 1, 4'hF, 0, 6'h00, 4'h0, 2'd0));
    // no bypass: enqueue into empty FIFO with consumer ready
    tbl.push_back(mk(4'b0001, {18'h0, 6'h3C}, {12'h0, 4'h6}, 1, 4'hF, 0, 6'h00, 4'h0, 2'd0));
    tbl.push_back(mk(4'b0000, '0, '0, 1, 4'hF, 1, 6'h3C, 4'h6, 2'd0));
    tbl.push_back(mk(4'b0000, '0, '0, 0, 4'hF, 0, 6'h00, 4'h0, 2'd0));
    // depth fill on ch2, write while full ignored, then drain
    tbl.push_back(mk(4'b0100, {6'h0, 6'h2A, 12'h0}, {4'h0, 4'h5, 8'h0}, 0, 4'hF, 0, 6'h00, 4'h0, 2'd0));
    tbl.push_back(mk(4'b0100, {6'h0, 6'h01, 12'h0}, {4'h0, 4'h1, 8'h0}, 0, 4'hF, 0, 6'h2A, 4'h5, 2'd2));
    tbl.push_back(mk(4'b0100, {6'h0, 6'h02, 12'h0}, {4'h0, 4'h2, 8'h0}, 0, 4'hF, 0, 6'h2A, 4'h5, 2'd2));
    tbl.push_back(mk(4'b0100, {6'h0, 6'h03, 12'h0}, {4'h0, 4'h3, 8'h0}, 0, 4'hF, 0, 6'h2A, 4'h5, 2'd2));
    tbl.push_back(mk(4'b0100, {6'h0, 6'h3F, 12'h0}, {4'h0, 4'hF, 8'h0}, 0, 4'b1011, 0, 6'h2A, 4'h5, 2'd2));
    tbl.push_back(mk(4'b0000, '0, '0, 1, 4'b1011, 1, 6'h2A, 4'h5, 2'd2));
    tbl.push_back(mk(4'b0000, '0, '0, 1, 4'hF, 1, 6'h01, 4'h1, 2'd2));
    tbl.push_back(mk(4'b0000, '0, '0, 1, 4'hF, 1, 6'h02, 4'h2, 2'd2));
    tbl.push_back(mk(4'b0000, '0, '0, 1, 4'hF, 1, 6'h03, 4'h3, 2'd2));
    tbl.push_back(mk(4'b0000, '0, '0, 1, 4'hF, 0, 6'h00, 4'h0, 2'd0));
    foreach (tbl[i]) begin
      tick();
      say_ena = tbl[i].ena;
      say_meth = tbl[i].meth;
      say_v = tbl[i].v;
      h_rdy = tbl[i].hrdy;
      @(negedge CLK);
      chk($sformatf("v%0d_rdy", i), say_rdy, tbl[i].e_rdy);
      chk($sformatf("v%0d_ena", i), h_ena, tbl[i].e_ena);
      chk($sformatf("v%0d_meth", i), h_meth, tbl[i].e_meth);
      chk($sformatf("v%0d_v", i), h_v, tbl[i].e_v);
      chk($sformatf("v%0d_chan", i), h_chan, tbl[i].e_chan);
    end
    // back-pressure: toggle consumer ready, enqueue on ch1 whenever not full
    mcnt = 0;
    h_rdy = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      h_rdy = ~h_rdy;
      say_ena = (mcnt != 4) ? 4'b0010 : 4'b0000;
      w = 10'(c * 37 + 5);
      say_meth = {12'h0, w[5:0], 6'h0};
      say_v = {8'h0, w[9:6], 4'h0};
      @(negedge CLK);
      chk("bp_rdy", say_rdy[1], mcnt != 4);
      chk("bp_ena", h_ena, (mcnt != 0) && h_rdy);
      if (mcnt != 0 && h_rdy) begin
        chk("bp_data", {h_v, h_meth}, q[0]);
        chk("bp_chan", h_chan, 1);
        void'(q.pop_front());
        mcnt--;
      end
      if (say_ena[1]) begin
        q.push_back(w);
        mcnt++;
      end
    end
    tick();
    say_ena = '0;
    h_rdy = 1;
    for (int c = 0; c < 8 && mcnt > 0; c++) begin
      @(negedge CLK);
      chk("drain_ena", h_ena, 1);
      chk("drain_data", {h_v, h_meth}, q[0]);
      void'(q.pop_front());
      mcnt--;
      tick();
    end
    @(negedge CLK);
    chk("drain_done", h_ena, 0);
    // asynchronous reset mid-stream with 3 words buffered on ch0
    h_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      say_ena = 4'b0001;
      say_meth = {18'h0, 6'(6'h11 + k)};
      say_v = {12'h0, 4'(k + 1)};
    end
    tick();
    say_ena = '0;
    h_rdy = 1;
    #2;
    chk("rst_pre_ena", h_ena, 1);
    nRST = 0;
    #1;
    chk("rst_async_ena", h_ena, 0);
    chk("rst_async_rdy", say_rdy, 4'hF);
    chk("rst_async_meth", h_meth, 0);
    chk("rst_async_chan", h_chan, 0);
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge CLK);
      chk("rst_no_stale", h_ena, 0);
    end
    tick();
    say_ena = 4'b0010;
    say_meth = {12'h0, 6'h2B, 6'h0};
    say_v = {8'h0, 4'h9, 4'h0};
    @(negedge CLK);
    chk("post_rst_nobypass", h_ena, 0);
    tick();
    say_ena = '0;
    @(negedge CLK);
    chk("post_rst_ena", h_ena, 1);
    chk("post_rst_word", {h_chan, h_v, h_meth}, {2'd1, 4'h9, 6'h2B});
    tick();
    @(negedge CLK);
    chk("post_rst_empty", h_ena, 0);
`ifdef IVECTOR_ARB_STATS_EN
    #1;
    nRST = 0;
    #1;
    nRST = 1;
    h_rdy = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      say_ena = 4'b0001;
      say_meth = {18'h0, 6'(k)};
    end
    tick();
    say_ena = '0;
    tick();
    tick();
    @(negedge CLK);
    chk("stat_count", st_cnt, 10);
    h_rdy = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      say_ena = 4'b1000;
    end
    tick();
    say_ena = '0;
    tick();
    @(negedge CLK);
    chk("stat_full", st_full, 4'b1000);
    h_rdy = 1;
    repeat (6) tick();
    @(negedge CLK);
    chk("stat_full_sticky", st_full, 4'b1000);
    chk("stat_count_total", st_cnt, 14);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
